membus_arbiter: RTL and testbench
=================================

# membus_arbiter

Two-to-one memory-bus arbiter that shares a single memory port between the core's instruction bus (ibus) and data bus (dbus). It sits in the SoC top between `riscv_ic` and the memory model or RAM. It latches each granted request and drives the memory port from registers. Completion is returned to the winning requester as a one-cycle ready pulse with registered read data and an error flag. A watchdog completes any access the memory fails to acknowledge.

## Interface
Parameters:
- ADDR_W, 32, address width (`MemAddrBus`)
- DATA_W, 32, data width (`MemDataBus`)
- MASK_W, 4, byte-mask width (`DBUS_MASK`)
- TIMEOUT, 255, maximum cycles in BUSY without `mem_ack` (≥1)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  system clock
  - rst  in  1  asynchronous active-low reset
- ibus requester:
  - ibus_req, ibus_we  in  1  request / write enable
  - ibus_addr  in  ADDR_W; ibus_wdata  in  DATA_W; ibus_mask  in  MASK_W
  - ibus_rdata  out  DATA_W; ibus_ready  out  1; ibus_err  out  1
- dbus requester:
  - dbus_* mirror the ibus_* ports exactly.
- Memory port:
  - mem_req, mem_we  out  1
  - mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_mask  out  MASK_W
  - mem_rdata  in  DATA_W; mem_ack  in  1

## Operation
- State machine: IDLE, BUSY, RESP.
- IDLE:
  - If any request is pending, choose a winner.
  - Latch the winner's we/addr/wdata/mask into the memory-port registers, record the winner, clear the watchdog, and go to BUSY.
  - With no request pending, stay in IDLE.
- Arbitration is round-robin on a `last` bit.
  - If only one bus requests, it wins.
  - If both request, the bus not equal to `last` wins.
  - `last` updates on every grant. Reset value of `last` is dbus, so ibus wins the first tie.
- BUSY:
  - mem_req = 1 and the memory-port fields are held constant.
  - If mem_ack = 1: capture mem_rdata, set err = 0, go to RESP.
  - Otherwise, if the watchdog has reached TIMEOUT-1: capture rdata = 0, set err = 1, go to RESP.
  - Otherwise, increment the watchdog.
- RESP:
  - Assert the winner's ready for exactly one cycle, with its rdata/err valid.
  - The loser's ready stays 0. No arbitration happens this cycle. Return to IDLE.
- Requester contract:
  - Hold req and its fields stable from assertion until ready is seen.
  - A req sampled in IDLE after a RESP is a new request.
- Memory contract:
  - The memory abandons any transaction when mem_req falls.
  - mem_ack outside BUSY is ignored.
  - An ack arriving in the same cycle as the timeout wins: err = 0.
- rdata/err registers hold their last value between responses. The losing bus's rdata is not updated.
- Reset, at any time including mid-BUSY:
  - State goes to IDLE, `last` goes to dbus, and the watchdog clears.
  - All outputs go to 0: mem_req, mem_we, mem_addr, mem_wdata, mem_mask, both readys, both errs, both rdatas.
  - An in-flight transaction is dropped and no ready is issued.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Request sampled in IDLE at cycle 0: mem_req rises at cycle 1.
- mem_ack at cycle N (N ≥ 1): ready = 1 at cycle N+1, mem_req = 0 at cycle N+1.
- Minimum latency from req to ready is 2 cycles with a same-cycle ack at cycle 1.
- Back-to-back service: a next request sampled in IDLE at N+2 gives mem_req at N+3.
- Timeout with no ack: mem_req stays high for TIMEOUT cycles (1..TIMEOUT), and ready with err = 1 comes at cycle TIMEOUT+1.
- Watchdog width is $clog2(TIMEOUT+1). The counter saturates and never wraps.

## Structure
- The shared defines file provides `MemAddrBus`, `MemDataBus`, `DBUS_MASK`, and new `ARB_IDLE`/`ARB_BUSY`/`ARB_RESP` state encodings (2-bit).
- Sub-module `rr_arb2` is the combinational two-way round-robin picker:
  - Inputs: req[1:0], last.
  - Outputs: gnt[1:0] one-hot, any.
  - It is reusable for future masters such as a DMA or debug port.
- The top instantiates the arbiter between `riscv_ic` and the single pmem/RAM port. The existing unused `ibus_ready`/`dbus_ready` wires connect to it.

## Test plan
- ibus-only read:
  - Stimulus: ibus_req = 1, addr = 0x8000_0000; memory acks 1 cycle after mem_req with 0x0000_0413.
  - Response: mem_addr = 0x8000_0000 at cycle 1; ibus_ready pulse at cycle 3 with rdata = 0x0000_0413, err = 0.
- Simultaneous requests, three rounds:
  - Stimulus: ibus and dbus held high.
  - Response: grant order is ibus, dbus, ibus; each ready is exactly 1 cycle wide and the loser's rdata is unchanged.
- dbus write:
  - Stimulus: addr = 0x8000_1004, wdata = 0xA5A5_5A5A, mask = 4'b0011, we = 1.
  - Response: the memory port shows identical fields held stable through BUSY; dbus_ready follows the ack by one cycle.
- Timeout:
  - Stimulus: TIMEOUT = 4, memory never acks.
  - Response: mem_req high for exactly 4 cycles; at cycle 5, ready = 1, err = 1, rdata = 0; a later stray ack is ignored.
- Ack in the timeout cycle:
  - Stimulus: TIMEOUT = 4, mem_ack arrives in the 4th BUSY cycle with data 0x1234_5678.
  - Response: err = 0, rdata = 0x1234_5678.
- Reset mid-BUSY:
  - Stimulus: rst = 0 asserted asynchronously in BUSY.
  - Response: all outputs are 0 immediately; no ready follows; after release, a pending tie is granted to ibus first.

Source files
------------

// File: rtl/membus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : membus_arbiter_pkg
//  Purpose  : Shared definitions for the two-to-one memory-bus arbiter:
//             default bus widths, bus indices and arbiter state encodings.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package membus_arbiter_pkg;

  // Default memory-bus geometry.
  localparam int c_mem_addr_bus = 32;
  localparam int c_mem_data_bus = 32;
  localparam int c_dbus_mask    = 4;

  // Requester indices; also the encoding of the round-robin `last` bit.
  localparam logic c_bus_ibus = 1'b0;
  localparam logic c_bus_dbus = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/membus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : membus_arbiter_if
//  Purpose  : Bundles the ibus/dbus requester ports and the shared memory port.
//  Ports    : ibus_* / dbus_*  requester side (req, we, addr, wdata, mask in;
//                              rdata, ready, err out of the arbiter)
//             mem_*            memory side (req, we, addr, wdata, mask out of
//                              the arbiter; rdata, ack into it)
//             modport slave  : arbiter view
//             modport master : environment view (requesters + memory)
//  Revision : 1.0 - initial release
// ============================================================================
interface membus_arbiter_if
  import membus_arbiter_pkg::*;
#(
  parameter int ADDR_W = c_mem_addr_bus,
  parameter int DATA_W = c_mem_data_bus,
  parameter int MASK_W = c_dbus_mask
) ();

  logic              ibus_req;
  logic              ibus_we;
  logic [ADDR_W-1:0] ibus_addr;
  logic [DATA_W-1:0] ibus_wdata;
  logic [MASK_W-1:0] ibus_mask;
  logic [DATA_W-1:0] ibus_rdata;
  logic              ibus_ready;
  logic              ibus_err;

  logic              dbus_req;
  logic              dbus_we;
  logic [ADDR_W-1:0] dbus_addr;
  logic [DATA_W-1:0] dbus_wdata;
  logic [MASK_W-1:0] dbus_mask;
  logic [DATA_W-1:0] dbus_rdata;
  logic              dbus_ready;
  logic              dbus_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_mask;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  ibus_req, ibus_we, ibus_addr, ibus_wdata, ibus_mask,
    output ibus_rdata, ibus_ready, ibus_err,
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_mask,
    output dbus_rdata, dbus_ready, dbus_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
    input  mem_rdata, mem_ack
  );

  modport master (
    output ibus_req, ibus_we, ibus_addr, ibus_wdata, ibus_mask,
    input  ibus_rdata, ibus_ready, ibus_err,
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_mask,
    input  dbus_rdata, dbus_ready, dbus_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
    output mem_rdata, mem_ack
  );

endinterface
`default_nettype wire

// File: rtl/membus_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Combinational two-way round-robin picker. A lone requester
//             wins; on a tie the requester not equal to `last` wins.
//  Ports    : req[1:0] in  request vector (bit index = requester id)
//             last     in  id of the previous winner
//             gnt[1:0] out one-hot grant (zero when no request)
//             any      out at least one request present
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  wire logic [1:0] req,
  input  wire logic       last,
  output logic      [1:0] gnt,
  output logic            any
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

  assign any = |req;

endmodule
`default_nettype wire

// File: rtl/membus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : membus_arbiter
//  Purpose  : Shares one memory port between the instruction bus and the data
//             bus. A granted request is latched into the memory-port
//             registers; completion returns a one-cycle ready pulse with
//             registered rdata/err to the winner. A watchdog completes any
//             access the memory does not acknowledge within TIMEOUT cycles.
//  Ports    : clk  in  system clock
//             rst  in  asynchronous active-low reset
//             bus  membus_arbiter_if.slave (ibus, dbus and memory port)
//  Revision : 1.0 - initial release
// ============================================================================
module membus_arbiter
  import membus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = c_mem_addr_bus,
  parameter int DATA_W  = c_mem_data_bus,
  parameter int MASK_W  = c_dbus_mask,
  parameter int TIMEOUT = 255
) (
  input wire logic         clk,
  input wire logic         rst,
  membus_arbiter_if.slave  bus
);

  localparam int                c_wd_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);

  arb_state_t        r_state, w_state;
  logic              r_last, w_last;
  logic              r_win, w_win;
  logic [c_wd_w-1:0] r_wd, w_wd;
  logic              r_mem_req, w_mem_req;
  logic              r_mem_we, w_mem_we;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
  logic [MASK_W-1:0] r_mem_mask, w_mem_mask;
  logic [1:0]        r_ready, w_ready;
  logic [1:0]        r_err, w_err;
  logic [DATA_W-1:0] r_rdata_i, w_rdata_i;
  logic [DATA_W-1:0] r_rdata_d, w_rdata_d;

  logic [1:0]        w_gnt;
  logic              w_any;
  logic              w_done;
  logic              w_done_err;
  logic [DATA_W-1:0] w_done_data;

  rr_arb2 u_rr_arb2 (
    .req  ({bus.dbus_req, bus.ibus_req}),
    .last (r_last),
    .gnt  (w_gnt),
    .any  (w_any)
  );

  always_comb begin
    w_state     = r_state;
    w_last      = r_last;
    w_win       = r_win;
    w_wd        = r_wd;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_mem_mask  = r_mem_mask;
    w_ready     = 2'b00;
    w_err       = r_err;
    w_rdata_i   = r_rdata_i;
    w_rdata_d   = r_rdata_d;
    w_done      = 1'b0;
    w_done_err  = 1'b0;
    w_done_data = '0;

    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_win     = w_gnt[1] ? c_bus_dbus : c_bus_ibus;
          w_last    = w_win;
          w_mem_req = 1'b1;
          w_wd      = '0;
          w_state   = ARB_BUSY;
          if (w_gnt[0]) begin
            w_mem_we    = bus.ibus_we;
            w_mem_addr  = bus.ibus_addr;
            w_mem_wdata = bus.ibus_wdata;
            w_mem_mask  = bus.ibus_mask;
          end else begin
            w_mem_we    = bus.dbus_we;
            w_mem_addr  = bus.dbus_addr;
            w_mem_wdata = bus.dbus_wdata;
            w_mem_mask  = bus.dbus_mask;
          end
        end
      end
      ARB_BUSY: begin
        // An ack in the same cycle as the watchdog expiry takes priority.
        if (bus.mem_ack) begin
          w_done      = 1'b1;
          w_done_data = bus.mem_rdata;
        end else if (r_wd == c_wd_last) begin
          w_done     = 1'b1;
          w_done_err = 1'b1;
        end else if (r_wd != '1) begin
          w_wd = r_wd + 1'b1;
        end
      end
      ARB_RESP: begin
        // Ready is high for this single cycle; no arbitration here.
        w_state = ARB_IDLE;
      end
      default: w_state = ARB_IDLE;
    endcase

    // Only the winner's response registers change.
    if (w_done) begin
      w_state        = ARB_RESP;
      w_mem_req      = 1'b0;
      w_ready[r_win] = 1'b1;
      w_err[r_win]   = w_done_err;
      if (r_win == c_bus_dbus) begin
        w_rdata_d = w_done_data;
      end else begin
        w_rdata_i = w_done_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ARB_IDLE;
      r_last      <= c_bus_dbus;
      r_win       <= c_bus_ibus;
      r_wd        <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_mask  <= '0;
      r_ready     <= 2'b00;
      r_err       <= 2'b00;
      r_rdata_i   <= '0;
      r_rdata_d   <= '0;
    end else begin
      r_state     <= w_state;
      r_last      <= w_last;
      r_win       <= w_win;
      r_wd        <= w_wd;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_mask  <= w_mem_mask;
      r_ready     <= w_ready;
      r_err       <= w_err;
      r_rdata_i   <= w_rdata_i;
      r_rdata_d   <= w_rdata_d;
    end
  end

  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_mask   = r_mem_mask;
  assign bus.ibus_ready = r_ready[0];
  assign bus.dbus_ready = r_ready[1];
  assign bus.ibus_err   = r_err[0];
  assign bus.dbus_err   = r_err[1];
  assign bus.ibus_rdata = r_rdata_i;
  assign bus.dbus_rdata = r_rdata_d;

endmodule
`default_nettype wire

// File: tb/tb_membus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_membus_arbiter
//  Purpose  : Self-checking bench for membus_arbiter (TIMEOUT = 4). Directed
//             scenarios with literal expectations, then randomized traffic,
//             all compared every cycle against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_membus_arbiter;
  import membus_arbiter_pkg::*;

  localparam int TIMEOUT = 4;

  logic clk;
  logic rst;

  membus_arbiter_if #(.ADDR_W(32), .DATA_W(32), .MASK_W(4)) bus ();

  membus_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .MASK_W (4),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // Index 0 = ibus, 1 = dbus.
  logic        m_inflight;
  int          m_age;          // BUSY cycles elapsed for the current access
  logic        m_win;
  logic        m_last;
  logic        exp_mem_we;
  logic [31:0] exp_mem_addr;
  logic [31:0] exp_mem_wdata;
  logic [3:0]  exp_mem_mask;
  logic [1:0]  exp_ready;
  logic [1:0]  exp_err;
  logic [31:0] exp_rdata [2];

  task model_reset;
    m_inflight    = 1'b0;
    m_age         = 0;
    m_win         = 1'b0;
    m_last        = 1'b1;
    exp_mem_we    = 1'b0;
    exp_mem_addr  = '0;
    exp_mem_wdata = '0;
    exp_mem_mask  = '0;
    exp_ready     = 2'b00;
    exp_err       = 2'b00;
    exp_rdata[0]  = '0;
    exp_rdata[1]  = '0;
  endtask

  task model_complete(input logic [31:0] d, input logic e);
    m_inflight       = 1'b0;
    exp_ready[m_win] = 1'b1;
    exp_rdata[m_win] = d;
    exp_err[m_win]   = e;
  endtask

  task model_step;
    logic was_resp;
    if (!rst) begin
      model_reset();
    end else begin
      was_resp  = |exp_ready;
      exp_ready = 2'b00;
      if (m_inflight) begin
        m_age = m_age + 1;
        if (bus.mem_ack)            model_complete(bus.mem_rdata, 1'b0);
        else if (m_age == TIMEOUT)  model_complete(32'h0, 1'b1);
      end else if (!was_resp && (bus.ibus_req || bus.dbus_req)) begin
        if (bus.ibus_req && bus.dbus_req) m_win = ~m_last;
        else                              m_win = bus.dbus_req;
        m_last     = m_win;
        m_inflight = 1'b1;
        m_age      = 0;
        if (m_win) begin
          exp_mem_we = bus.dbus_we;   exp_mem_addr = bus.dbus_addr;
          exp_mem_wdata = bus.dbus_wdata; exp_mem_mask = bus.dbus_mask;
        end else begin
          exp_mem_we = bus.ibus_we;   exp_mem_addr = bus.ibus_addr;
          exp_mem_wdata = bus.ibus_wdata; exp_mem_mask = bus.ibus_mask;
        end
      end
    end
  endtask

  initial model_reset();

  // Compare process: model advances on each edge, DUT sampled 1 ns later.
  always @(posedge clk) begin
    model_step();
    #1;
    chk("mem_req",    bus.mem_req,    m_inflight);
    chk("mem_we",     bus.mem_we,     exp_mem_we);
    chk("mem_addr",   bus.mem_addr,   exp_mem_addr);
    chk("mem_wdata",  bus.mem_wdata,  exp_mem_wdata);
    chk("mem_mask",   bus.mem_mask,   exp_mem_mask);
    chk("ibus_ready", bus.ibus_ready, exp_ready[0]);
    chk("dbus_ready", bus.dbus_ready, exp_ready[1]);
    chk("ibus_err",   bus.ibus_err,   exp_err[0]);
    chk("dbus_err",   bus.dbus_err,   exp_err[1]);
    chk("ibus_rdata", bus.ibus_rdata, exp_rdata[0]);
    chk("dbus_rdata", bus.dbus_rdata, exp_rdata[1]);
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Advance until some ready is seen; who = 0 ibus, 1 dbus, 2 none in budget.
  task automatic wait_ready(input int budget, output int who);
    who = 2;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.ibus_ready) begin who = 0; break; end
      if (bus.dbus_ready) begin who = 1; break; end
    end
  endtask

  task automatic idle_inputs;
    bus.ibus_req = 0; bus.ibus_we = 0; bus.ibus_addr = 0; bus.ibus_wdata = 0; bus.ibus_mask = 0;
    bus.dbus_req = 0; bus.dbus_we = 0; bus.dbus_addr = 0; bus.dbus_wdata = 0; bus.dbus_mask = 0;
    bus.mem_ack = 0;  bus.mem_rdata = 0;
  endtask

  logic        pend [2];
  logic        r_we [2];
  logic [31:0] r_ad [2];
  logic [31:0] r_wd [2];
  logic [3:0]  r_mk [2];
  int          plan;
  logic        plan_valid;

  initial begin
    int who;
    int cnt;
    int rdy_cyc;

    rst = 1'b0;
    idle_inputs();
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // ---- simultaneous requests, three rounds: ibus, dbus, ibus ----
    bus.ibus_req = 1; bus.ibus_addr = 32'h0000_0100;
    bus.dbus_req = 1; bus.dbus_addr = 32'h0000_0200;
    bus.mem_ack = 1;  bus.mem_rdata = 32'hD0D0_0001;
    wait_ready(10, who);
    chk("tie_round1_winner", who, 0);
    bus.mem_rdata = 32'hD0D0_0002;
    wait_ready(10, who);
    chk("tie_round2_winner", who, 1);
    chk("tie_round2_ibus_rdata_held", bus.ibus_rdata, 32'hD0D0_0001);
    bus.mem_rdata = 32'hD0D0_0003;
    wait_ready(10, who);
    chk("tie_round3_winner", who, 0);
    chk("tie_round3_dbus_rdata_held", bus.dbus_rdata, 32'hD0D0_0002);
    idle_inputs();
    tick(); tick();

    // ---- ibus-only read ----
    bus.ibus_req = 1; bus.ibus_addr = 32'h8000_0000;
    tick();                                   // cycle 1
    chk("read_c1_mem_req", bus.mem_req, 1);
    chk("read_c1_mem_addr", bus.mem_addr, 32'h8000_0000);
    tick();                                   // cycle 2
    bus.mem_ack = 1; bus.mem_rdata = 32'h0000_0413;
    tick();                                   // cycle 3
    chk("read_c3_ibus_ready", bus.ibus_ready, 1);
    chk("read_c3_ibus_rdata", bus.ibus_rdata, 32'h0000_0413);
    chk("read_c3_ibus_err", bus.ibus_err, 0);
    idle_inputs();
    tick();

    // ---- dbus write ----
    bus.dbus_req = 1; bus.dbus_we = 1; bus.dbus_addr = 32'h8000_1004;
    bus.dbus_wdata = 32'hA5A5_5A5A; bus.dbus_mask = 4'b0011;
    tick();                                   // cycle 1
    chk("wr_c1_mem_we", bus.mem_we, 1);
    chk("wr_c1_mem_addr", bus.mem_addr, 32'h8000_1004);
    chk("wr_c1_mem_wdata", bus.mem_wdata, 32'hA5A5_5A5A);
    chk("wr_c1_mem_mask", bus.mem_mask, 4'b0011);
    tick();                                   // cycle 2
    bus.mem_ack = 1;
    tick();                                   // cycle 3
    chk("wr_c3_dbus_ready", bus.dbus_ready, 1);
    chk("wr_c3_ibus_ready", bus.ibus_ready, 0);
    chk("wr_c3_mem_req", bus.mem_req, 0);
    idle_inputs();
    tick();

    // ---- timeout, then stray acks ----
    bus.ibus_req = 1; bus.ibus_addr = 32'h0000_0040;
    cnt = 0; rdy_cyc = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.mem_req) cnt++;
      if (bus.ibus_ready && rdy_cyc == 0) begin
        rdy_cyc = i;
        chk("to_err", bus.ibus_err, 1);
        chk("to_rdata", bus.ibus_rdata, 0);
        bus.ibus_req = 0;
      end
    end
    chk("to_mem_req_cycles", cnt, TIMEOUT);
    chk("to_ready_cycle", rdy_cyc, TIMEOUT + 1);
    bus.ibus_req = 0;
    bus.mem_ack = 1; bus.mem_rdata = 32'hBAD0_BAD0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.ibus_ready || bus.dbus_ready || bus.mem_req) cnt++;
    end
    chk("stray_ack_ignored", cnt, 0);
    idle_inputs();
    tick();

    // ---- ack in the timeout cycle wins ----
    bus.ibus_req = 1; bus.ibus_addr = 32'h0000_0080;
    tick(); tick(); tick(); tick();           // cycles 1..4
    bus.mem_ack = 1; bus.mem_rdata = 32'h1234_5678;
    tick();                                   // cycle 5
    chk("lastack_ready", bus.ibus_ready, 1);
    chk("lastack_err", bus.ibus_err, 0);
    chk("lastack_rdata", bus.ibus_rdata, 32'h1234_5678);
    idle_inputs();
    tick();

    // ---- reset mid-BUSY; pending tie goes to ibus afterwards ----
    bus.ibus_req = 1; bus.ibus_addr = 32'h0000_0300;
    bus.dbus_req = 1; bus.dbus_addr = 32'h0000_0400;
    tick(); tick();
    #1 rst = 1'b0;
    #1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_ibus_rdata", bus.ibus_rdata, 0);
    chk("rst_dbus_rdata", bus.dbus_rdata, 0);
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (bus.ibus_ready || bus.dbus_ready) cnt++;
    end
    chk("rst_no_ready", cnt, 0);
    rst = 1'b1;
    bus.mem_ack = 1; bus.mem_rdata = 32'h0000_0777;
    wait_ready(10, who);
    chk("rst_tie_winner", who, 0);
    idle_inputs();
    tick(); tick();

    // ---- randomized traffic ----
    for (int b = 0; b < 2; b++) pend[b] = 1'b0;
    plan_valid = 1'b0;
    plan = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 2; b++) begin
        if (pend[b] && exp_ready[b]) pend[b] = 1'b0;
        if (!pend[b] && ($urandom_range(0, 2) == 0)) begin
          pend[b] = 1'b1;
          r_we[b] = 1'($urandom);
          r_ad[b] = $urandom;
          r_wd[b] = $urandom;
          r_mk[b] = 4'($urandom);
        end
      end
      bus.ibus_req = pend[0]; bus.ibus_we = r_we[0]; bus.ibus_addr = r_ad[0];
      bus.ibus_wdata = r_wd[0]; bus.ibus_mask = r_mk[0];
      bus.dbus_req = pend[1]; bus.dbus_we = r_we[1]; bus.dbus_addr = r_ad[1];
      bus.dbus_wdata = r_wd[1]; bus.dbus_mask = r_mk[1];
      if (m_inflight) begin
        if (!plan_valid) begin
          plan = $urandom_range(1, TIMEOUT + 2);  // beyond TIMEOUT never acks
          plan_valid = 1'b1;
        end
        bus.mem_ack = (m_age + 1 == plan);
      end else begin
        plan_valid = 1'b0;
        bus.mem_ack = ($urandom_range(0, 7) == 0);
      end
      bus.mem_rdata = $urandom;
      tick();
    end

    idle_inputs();
    repeat (8) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
